// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file and its scan engine.
package regfile_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_DEPTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } scan_state_e;

    // Index of the register that is hardwired to zero when that option is on.
    function automatic int zero_idx(input int depth);
        return depth - 1;
    endfunction

endpackage

// File: rtl/regfile_scan.sv
// Debug scan engine: walks every register index once and presents each one as
// a valid/ready beat. The storage read itself happens in the parent.
module regfile_scan
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             scan_start,
    input  logic             scan_ready,
    input  logic [WIDTH-1:0] rd_data,
    output logic             scan_valid,
    output logic [AW-1:0]    scan_idx,
    output logic [WIDTH-1:0] scan_data,
    output logic             scan_busy
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    scan_state_e   state;
    logic [AW-1:0] idx;

    // Scan FSM and index counter; the index only moves on an accepted beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= '0;
        end else if (state == IDLE) begin
            if (scan_start) begin
                state <= RUN;
                idx   <= '0;
            end
        end else if (scan_ready) begin
            if (idx == LAST) begin
                state <= IDLE;
                idx   <= '0;
            end else begin
                idx <= idx + AW'(1);
            end
        end
    end

    assign scan_valid = (state == RUN);
    assign scan_busy  = (state == RUN);
    assign scan_idx   = idx;
    // Data is live storage, so it follows writes while a beat is stalled.
    assign scan_data  = scan_valid ? rd_data : '0;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NREAD combinational read ports, two write ports
// (port 1 wins on collision), optional write-to-read bypass, optional
// hardwired-zero top register, and a debug scan port.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int NREAD   = 2,
    parameter int ZERO_EN = 1,
    parameter int BYPASS  = 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [1:0]             wr_en,
    input  logic [2*AW-1:0]        wr_addr,
    input  logic [2*WIDTH-1:0]     wr_data,
    input  logic [NREAD*AW-1:0]    rd_addr,
    output logic [NREAD*WIDTH-1:0] rd_data,
    input  logic                   scan_start,
    input  logic                   scan_ready,
    output logic                   scan_valid,
    output logic [AW-1:0]          scan_idx,
    output logic [WIDTH-1:0]       scan_data,
    output logic                   scan_busy
);

    localparam logic [AW-1:0] ZADDR = AW'(zero_idx(DEPTH));

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wa  [2];
    logic [WIDTH-1:0] wd  [2];
    logic [WIDTH-1:0] scan_rdata;

    assign wa[0] = wr_addr[AW-1:0];
    assign wa[1] = wr_addr[2*AW-1:AW];
    assign wd[0] = wr_data[WIDTH-1:0];
    assign wd[1] = wr_data[2*WIDTH-1:WIDTH];

    // Storage: port 1 is applied after port 0 so it wins a same-address write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (wr_en[p] && !((ZERO_EN != 0) && (wa[p] == ZADDR)))
                    mem[wa[p]] <= wd[p];
            end
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] val;

        assign ra = rd_addr[k*AW +: AW];

        // Read mux: stored value, then bypass (port 1 last), zero register last.
        always_comb begin
            val = mem[ra];
            if (BYPASS != 0) begin
                if (wr_en[0] && (wa[0] == ra)) val = wd[0];
                if (wr_en[1] && (wa[1] == ra)) val = wd[1];
            end
            if ((ZERO_EN != 0) && (ra == ZADDR)) val = '0;
        end

        assign rd_data[k*WIDTH +: WIDTH] = val;
    end

    // Scan read port: stored value only, never bypassed.
    always_comb begin
        scan_rdata = mem[scan_idx];
        if ((ZERO_EN != 0) && (scan_idx == ZADDR)) scan_rdata = '0;
    end

    regfile_scan #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_scan (
        .clk        (clk),
        .reset_n    (reset_n),
        .scan_start (scan_start),
        .scan_ready (scan_ready),
        .rd_data    (scan_rdata),
        .scan_valid (scan_valid),
        .scan_idx   (scan_idx),
        .scan_data  (scan_data),
        .scan_busy  (scan_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp. Instance a: defaults (64x32, 2 read ports,
// zero register and bypass on). Instance b: 32x16, 4 read ports, no zero
// register, no bypass.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // instance a
    logic [1:0]   a_wr_en = '0;
    logic [9:0]   a_wr_addr = '0;
    logic [127:0] a_wr_data = '0;
    logic [9:0]   a_rd_addr = '0;
    logic [127:0] a_rd_data;
    logic         a_scan_start = 1'b0, a_scan_ready = 1'b0;
    logic         a_scan_valid, a_scan_busy;
    logic [4:0]   a_scan_idx;
    logic [63:0]  a_scan_data;

    // instance b
    logic [1:0]   b_wr_en = '0;
    logic [7:0]   b_wr_addr = '0;
    logic [63:0]  b_wr_data = '0;
    logic [15:0]  b_rd_addr = '0;
    logic [127:0] b_rd_data;
    logic         b_scan_valid, b_scan_busy;
    logic [3:0]   b_scan_idx;
    logic [31:0]  b_scan_data;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_mp u_a (
        .clk(clk), .reset_n(reset_n),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .scan_start(a_scan_start), .scan_ready(a_scan_ready),
        .scan_valid(a_scan_valid), .scan_idx(a_scan_idx),
        .scan_data(a_scan_data), .scan_busy(a_scan_busy)
    );

    regfile_mp #(.WIDTH(32), .DEPTH(16), .NREAD(4), .ZERO_EN(0), .BYPASS(0)) u_b (
        .clk(clk), .reset_n(reset_n),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .scan_start(1'b0), .scan_ready(1'b0),
        .scan_valid(b_scan_valid), .scan_idx(b_scan_idx),
        .scan_data(b_scan_data), .scan_busy(b_scan_busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_wr(input int p, input logic [4:0] ad, input logic [63:0] d);
        a_wr_en[p] = 1'b1;
        a_wr_addr[p*5 +: 5] = ad;
        a_wr_data[p*64 +: 64] = d;
    endtask

    function automatic logic [63:0] a_pat(input int i);
        return (i == 31) ? 64'h0 : 64'(i) * 64'h0000010204080001;
    endfunction

    function automatic logic [31:0] b_pat(input int i);
        return 32'(i) * 32'h01020401;
    endfunction

    // Runs one full scan on instance a, checking every cycle of it.
    task automatic run_scan(input bit stall);
        int  exp_idx = 0;
        int  cyc = 0;
        bit  done = 0;
        bit  r;
        a_scan_start = 1'b1;
        tick();
        a_scan_start = 1'b0;
        while (!done && cyc < 300) begin
            r = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            a_scan_ready = r;
            #1;
            chk("scan_valid", 64'(a_scan_valid), 64'd1);
            chk("scan_idx", 64'(a_scan_idx), 64'(exp_idx));
            chk("scan_data", a_scan_data, a_pat(exp_idx));
            tick();
            if (r) begin
                if (exp_idx == 31) done = 1;
                else exp_idx++;
            end
            cyc++;
        end
        a_scan_ready = 1'b0;
        if (!done) chk("scan_timeout", 64'd0, 64'd1);
        if (!stall) chk("scan_cycles", 64'(cyc), 64'd32);
        #1;
        chk("scan_busy_end", 64'(a_scan_busy), 64'd0);
        chk("scan_valid_end", 64'(a_scan_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        #12;
        chk("rst_rd0", a_rd_data[63:0], 64'h0);
        chk("rst_valid", 64'(a_scan_valid), 64'd0);
        chk("rst_busy", 64'(a_scan_busy), 64'd0);
        chk("rst_idx", 64'(a_scan_idx), 64'd0);
        chk("rst_sdata", a_scan_data, 64'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // fill regs 0..30 with A5, then async reset mid-cycle
        for (int i = 0; i < 31; i++) begin
            a_wr_en = '0;
            a_wr(0, 5'(i), 64'hA5);
            tick();
        end
        a_wr_en = '0;
        a_rd_addr = {5'd30, 5'd0};
        #1;
        chk("fill_r0", a_rd_data[63:0], 64'hA5);
        chk("fill_r30", a_rd_data[127:64], 64'hA5);
        #2 reset_n = 1'b0;
        #1;
        chk("clr_r0", a_rd_data[63:0], 64'h0);
        chk("clr_r30", a_rd_data[127:64], 64'h0);
        chk("clr_valid", 64'(a_scan_valid), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // zero register (a) and ordinary top register without bypass (b)
        a_wr(0, 5'd31, 64'hA0);
        a_rd_addr[4:0] = 5'd31;
        b_wr_en = 2'b01; b_wr_addr[3:0] = 4'd15; b_wr_data[31:0] = 32'hA0;
        b_rd_addr[3:0] = 4'd15;
        #1;
        chk("zero_same", a_rd_data[63:0], 64'h0);
        chk("nozero_same", 64'(b_rd_data[31:0]), 64'h0);
        tick();
        a_wr_en = '0; b_wr_en = '0;
        #1;
        chk("zero_next", a_rd_data[63:0], 64'h0);
        chk("nozero_next", 64'(b_rd_data[31:0]), 64'hA0);

        // write collision on address 5, plus a port-0-only bypass on a
        a_wr_en = 2'b11; a_wr_addr = {5'd5, 5'd5}; a_wr_data = {64'h22, 64'h11};
        b_wr_en = 2'b11; b_wr_addr = {4'd5, 4'd5}; b_wr_data = {32'h22, 32'h11};
        a_rd_addr[4:0] = 5'd5; b_rd_addr[3:0] = 4'd5;
        #1;
        chk("coll_byp", a_rd_data[63:0], 64'h22);
        chk("coll_nobyp", 64'(b_rd_data[31:0]), 64'h0);
        tick();
        a_wr_en = '0; b_wr_en = '0;
        #1;
        chk("coll_a_next", a_rd_data[63:0], 64'h22);
        chk("coll_b_next", 64'(b_rd_data[31:0]), 64'h22);
        a_wr(0, 5'd6, 64'h33);
        a_rd_addr[9:5] = 5'd6;
        #1;
        chk("byp_p0", a_rd_data[127:64], 64'h33);
        tick();
        a_wr_en = '0;

        // four-port sweep on b
        for (int i = 0; i < 16; i += 2) begin
            b_wr_en = 2'b11;
            b_wr_addr = {4'(i + 1), 4'(i)};
            b_wr_data = {b_pat(i + 1), b_pat(i)};
            tick();
        end
        b_wr_en = '0;
        b_rd_addr = {4'd9, 4'd0, 4'd15, 4'd3};
        #1;
        chk("sw_p0", 64'(b_rd_data[31:0]), 64'(b_pat(3)));
        chk("sw_p1", 64'(b_rd_data[63:32]), 64'(b_pat(15)));
        chk("sw_p2", 64'(b_rd_data[95:64]), 64'(b_pat(0)));
        chk("sw_p3", 64'(b_rd_data[127:96]), 64'(b_pat(9)));
        b_rd_addr = {4'd14, 4'd1, 4'd7, 4'd12};
        #1;
        chk("sw2_p0", 64'(b_rd_data[31:0]), 64'(b_pat(12)));
        chk("sw2_p1", 64'(b_rd_data[63:32]), 64'(b_pat(7)));
        chk("sw2_p2", 64'(b_rd_data[95:64]), 64'(b_pat(1)));
        chk("sw2_p3", 64'(b_rd_data[127:96]), 64'(b_pat(14)));

        // scan streaming: fill a, full-rate scan, then stalled scan
        for (int i = 0; i < 32; i++) begin
            a_wr_en = '0;
            a_wr(0, 5'(i), 64'(i) * 64'h0000010204080001);
            tick();
        end
        a_wr_en = '0;
        run_scan(1'b0);
        run_scan(1'b1);

        // scan interruption by reset at beat 10
        a_scan_start = 1'b1;
        tick();
        a_scan_start = 1'b0;
        a_scan_ready = 1'b1;
        repeat (10) tick();
        chk("int_idx10", 64'(a_scan_idx), 64'd10);
        chk("int_data10", a_scan_data, a_pat(10));
        #2 reset_n = 1'b0;
        #1;
        chk("int_valid", 64'(a_scan_valid), 64'd0);
        chk("int_busy", 64'(a_scan_busy), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick();
        chk("int_idle", 64'(a_scan_valid), 64'd0);
        a_scan_start = 1'b1;
        tick();
        a_scan_start = 1'b0;
        chk("restart_valid", 64'(a_scan_valid), 64'd1);
        chk("restart_idx", 64'(a_scan_idx), 64'd0);
        chk("restart_data", a_scan_data, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the pipelined processor, generalising the fixed 32×64, 2-read/1-write file. It adds configurable width, depth and read-port count, a second write port, same-cycle write-to-read bypass, an asynchronous clear, and a sequential debug-scan engine that streams every register out over a valid/ready handshake for board display or bench dumps.

## Interface
Parameters:
- WIDTH, 64, data bits per register
- DEPTH, 32, register count (power of two, ≥2); AW = $clog2(DEPTH)
- NREAD, 2, combinational read ports (≥1)
- ZERO_EN, 1, when 1 register DEPTH-1 is hardwired to zero
- BYPASS, 1, when 1 same-cycle write data is forwarded to read ports

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr_en  in  2  write enables, port 0 and port 1
- wr_addr  in  2×AW  write addresses
- wr_data  in  2×WIDTH  write data
- rd_addr  in  NREAD×AW  read addresses
- rd_data  out  NREAD×WIDTH  read data, combinational
- scan_start  in  1  request a full scan (sampled in IDLE only)
- scan_ready  in  1  consumer accepts current scan beat
- scan_valid  out  1  scan beat present
- scan_idx  out  AW  register index of current beat
- scan_data  out  WIDTH  register contents of current beat
- scan_busy  out  1  scan in progress

## Operation
- Reset (reset_n=0, asynchronous): all registers ← 0; scan FSM → IDLE; scan_valid=0, scan_busy=0, scan_idx=0, scan_data=0.
- Write: on clk rise, each port with wr_en=1 writes wr_data to wr_addr. Both ports same address: port 1 wins. Writes to register DEPTH-1 are discarded when ZERO_EN=1.
- Read: rd_data[k] = stored value of rd_addr[k]; register DEPTH-1 reads 0 when ZERO_EN=1, irrespective of writes or bypass.
- Bypass (BYPASS=1): if rd_addr[k] matches an enabled write address in the same cycle, rd_data[k] = that wr_data (port 1 over port 0). BYPASS=0: old value until the edge.
- Scan FSM, states IDLE, RUN:
  - IDLE: scan_start=1 → RUN, idx ← 0.
  - RUN: scan_valid=1, scan_busy=1, scan_data = stored value of reg[idx] (no bypass; zero reg reads 0). Beat accepted when scan_valid && scan_ready: idx<DEPTH-1 → idx+1; idx=DEPTH-1 → IDLE.
  - scan_start ignored in RUN. Writes during RUN are allowed; scan_data tracks the stored value of the current idx, so it may change while valid is held.

## Timing
- Write latency: stored value updates at the write edge; visible on non-bypassed reads the following cycle; bypassed reads see it combinationally in the write cycle.
- Reads: zero-cycle combinational from rd_addr.
- Scan: first beat (idx 0, valid=1) the cycle after scan_start is sampled in IDLE. One beat per cycle with scan_ready held at 1; full scan = DEPTH cycles; scan_busy falls, and scan_start is next sampled, the cycle after the final accept.
- scan_ready=0 stalls: idx held, valid held.
- reset_n asserted mid-scan: FSM to IDLE immediately, no partial completion; beats resume only on a new scan_start after release.
- Deassert reset_n synchronously to clk (external synchroniser).

## Structure
- Package regfile_pkg: default WIDTH/DEPTH constants, scan state enum (IDLE, RUN), ZERO_IDX function (DEPTH-1).
- Sub-module regfile_scan: scan FSM and index counter, reading through one internal read port without bypass; the top holds the storage array, write decode, priority and bypass muxes.

## Test plan
- Reset clear: write 0xA5 to regs 0–30, pulse reset_n low mid-cycle → all rd_data 0 immediately, scan_valid=0.
- Zero register: ZERO_EN=1, write 0xA0 to reg 31, read port 0 addr 31 → 0 same cycle and next; ZERO_EN=0 → 0xA0 next cycle.
- Write collision: wr_en=2'b11, both addr 5, data 0x11/0x22 → reg 5 = 0x22; bypassed read in write cycle = 0x22; BYPASS=0 → old value, then 0x22.
- Port-count sweep: NREAD=4, DEPTH=16, WIDTH=32, reg i = i×0x01020401 → all four ports read independent addresses correctly.
- Scan streaming: regs i = i×0x0000010204080001, scan_start, scan_ready=1 → 32 beats idx 0..31, data matches, busy low after beat 31 accept; random scan_ready stalls hold idx/data.
- Scan interruption: reset_n low at beat 10 → valid/busy 0 immediately; new scan_start after release → restarts at idx 0 with data 0.
